// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between four requesters,
// with optional exclusive lock and a timeout that force-releases a stuck lock.
module reg_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         lock,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic [1:0]         owner,
  output logic               locked,
  output logic               timeout
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx, owner_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [WIDTH-1:0] q_nx;
  logic [3:0]       ack_nx, eff;
  logic             locked_nx, timeout_nx;
  logic             win_vld;
  logic [1:0]       win;

  // A requester acked this cycle counts as served, so it cannot be granted twice in a row.
  assign eff = req & ~ack;

  always_comb begin
    win_vld = 1'b0;
    win     = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (eff[ptr + 2'(k)]) begin
        win_vld = 1'b1;
        win     = ptr + 2'(k);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    owner_nx   = owner;
    cnt_nx     = cnt;
    q_nx       = q;
    ack_nx     = 4'b0000;
    locked_nx  = locked;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          q_nx     = wdata[win*WIDTH +: WIDTH];
          ack_nx   = 4'b0001 << win;
          owner_nx = win;
          ptr_nx   = win + 2'd1;
          if (lock[win]) begin
            state_nx  = LOCKED;
            locked_nx = 1'b1;
            cnt_nx    = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (!lock[owner]) begin
          state_nx  = IDLE;
          locked_nx = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nx   = IDLE;
          locked_nx  = 1'b0;
          timeout_nx = 1'b1;
          ptr_nx     = owner + 2'd1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
        // The owner's write is still served on the exit cycle.
        if (eff[owner]) begin
          q_nx   = wdata[owner*WIDTH +: WIDTH];
          ack_nx = 4'b0001 << owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
      q       <= '0;
      ack     <= 4'b0000;
      owner   <= 2'd0;
      locked  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      q       <= q_nx;
      ack     <= ack_nx;
      owner   <= owner_nx;
      locked  <= locked_nx;
      timeout <= timeout_nx;
    end
  end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register between 4 requesters.
- Each requester presents a write word; the arbiter picks one winner per cycle, loads the register, and acknowledges the winner.
- A requester may lock the register for exclusive multi-cycle ownership. A timeout counter forcibly releases a stuck lock.
- Sits in front of the flip-flop register bank as its sequencing and sharing controller.

Parameters:
- WIDTH, 8, data width of the shared register and of each requester's write word.
- TIMEOUT, 16, maximum cycles a lock may be held before forced release; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester write request; held high until ack is seen.
- lock  input  4  per-requester lock request; sampled together with req.
- wdata  input  4*WIDTH  packed write words; requester i uses bits [i*WIDTH +: WIDTH].
- ack  output  4  one-hot, single-cycle, registered acknowledge.
- q  output  WIDTH  shared register contents.
- owner  output  2  index of the last winner.
- locked  output  1  high while in LOCKED state.
- timeout  output  1  single-cycle pulse when a lock is force-released.

Behaviour:
- Reset (asynchronous, immediate, holds while rst=1):
  - q=0, ack=0, owner=0, locked=0, timeout=0.
  - Round-robin pointer ptr=0, lock counter cnt=0, state=IDLE.
- Effective request: eff = req & ~ack. A requester whose ack is high this cycle is treated as already served, which prevents a double grant while it drops req.
- Latency: a winner sampled at edge N has q updated and ack[w]=1 in the cycle after edge N. Max throughput per requester is one write every 2 cycles; aggregate throughput is one write per cycle.
- IDLE state:
  - eff==0: ack<=0, nothing else changes.
  - eff!=0: winner w is the first set bit of eff searching ptr, ptr+1, ..., wrapping mod 4.
  - On a win: q<=wdata[w], ack<=onehot(w), owner<=w, ptr<=(w+1) mod 4.
  - If lock[w]=1 in the same cycle: go to LOCKED, locked<=1, cnt<=0.
- LOCKED state (owner fixed):
  - Exit check first. If lock[owner]=0, go to IDLE and set locked<=0.
  - Timeout check. Else if cnt==TIMEOUT-1, go to IDLE, set locked<=0, pulse timeout<=1 for one cycle, and set ptr<=(owner+1) mod 4.
  - Otherwise cnt<=cnt+1.
  - Independently of the exit checks, if eff[owner]=1 then q<=wdata[owner] and ack<=onehot(owner). This includes the exit cycle, so a final write is served.
  - req from non-owners is ignored in this state (no ack). Those requesters stall and must keep req high.
- Priority: LOCKED owner beats every other requester. In IDLE, round-robin order alone decides; there is no fixed priority.
- Pointer wrap: after winner 3, ptr=0.
- Forced release: lock stays high on the released owner's input. It can win again only through normal round-robin, so others ahead of ptr win first. If it is the sole requester, it re-wins and re-locks on the next eligible cycle.
- Reset mid-lock: state drops to IDLE immediately, and all outputs take their reset values at once.
- lock without req: ignored in IDLE, since lock only has effect for the cycle's winner.
- cnt width: 8 bits; it is cleared on every entry to LOCKED.
- Invariants: ack has at most one bit set; timeout is never high together with locked=1 in the same cycle.

Test Plan:
1. Reset then single write: rst 1->0; req=0001, wdata[0]=0xA5 for one cycle -> next cycle ack=0001, q=0xA5, owner=0; ptr=1; ack=0 the cycle after.
2. Round-robin fairness: req=1111 held with ack-driven drop/re-raise, each wdata[i]=0x10+i -> grant order 0,1,2,3,0; q sequence 0x10,0x11,0x12,0x13,0x10; never two consecutive acks to the same requester while others pend.
3. Lock and exclusivity: requester 2 wins with lock[2]=1; req[0]=1 held throughout; requester 2 writes 0x01, 0x02 -> locked=1, only ack[2] pulses, q=0x02; lock[2]->0 -> locked=0 next cycle, then ack[0] granted.
4. Timeout: TIMEOUT=16; requester 1 locks and keeps lock[1]=1 with req[3]=1 pending -> exactly 16 cycles after entry locked falls, timeout pulses 1 cycle, ptr=2, requester 3 is acked next.
5. Async reset mid-lock: assert rst between clock edges while locked=1, q=0x7E -> q=0, locked=0, ack=0, owner=0 immediately, with no clock edge needed.
6. Simultaneous ack/req: requester 0 keeps req high in its ack cycle with req[1]=1 -> requester 1 wins that cycle; no second ack[0] back-to-back.
